// File: rtl/ltc2195_emulator.sv
// LTC2195 transmit-side emulator: 4-lane SDR serializer for two 16-bit
// channels plus a frame lane, and the 16-bit SPI register slave that
// controls output formatting, test pattern and lane mode.
module ltc2195_emulator #(
  parameter int N_LANES         = 4,
  parameter int SCK_SYNC_STAGES = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [15:0]        ADC0_in,
  input  logic [15:0]        ADC1_in,
  output logic               frame_strobe_out,
  output logic [N_LANES-1:0] D0_out,
  output logic [N_LANES-1:0] D1_out,
  output logic               FR_out,
  input  logic               spi_scs_in,
  input  logic               spi_sck_in,
  input  logic               spi_sdi_in,
  output logic               spi_sdo_out,
  output logic               mode_err_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // ---------------------------------------------------------------------
  // Frame timing
  // ---------------------------------------------------------------------
  logic [1:0]  r_cnt;
  logic        w_capture;
  logic        r_fr;
  logic        r_mode_err;
  logic        w_bad_mode;

  // Control registers (reg0 is write-only: only its soft-reset bit acts)
  logic [7:0]  r_reg1;
  logic [7:0]  r_reg2;
  logic [7:0]  r_reg3;
  logic [7:0]  r_reg4;
  logic        r_soft_rst;
  logic [15:0] w_pattern;

  assign w_capture        = (r_cnt == 2'd3);
  assign frame_strobe_out = w_capture;
  assign w_bad_mode       = (r_reg2[1:0] != 2'b01);
  assign w_pattern        = {r_reg3[5:0], r_reg4, 2'b00};
  assign FR_out           = r_fr;
  assign mode_err_out     = r_mode_err;

  // Free-running 2-bit frame position counter
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_cnt <= 2'd0;
    else        r_cnt <= r_cnt + 2'd1;
  end

  // Frame lane (1,1,0,0 per frame) and lane-mode flag latched at the frame boundary
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_fr       <= 1'b0;
      r_mode_err <= 1'b0;
    end else begin
      r_fr <= (r_cnt == 2'd3) || (r_cnt == 2'd0);
      if (w_capture) r_mode_err <= w_bad_mode;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel formatter and lane serializer
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [15:0] w_adc;
      logic [15:0] w_fmt;
      logic [15:0] w_src;
      logic [15:0] r_shift;
      logic [3:0]  r_lanes;
      logic        w_blank;

      assign w_adc   = (gi == 0) ? ADC0_in : ADC1_in;
      // Mode used for this bit: the freshly latched one on the load cycle
      assign w_blank = w_capture ? w_bad_mode : r_mode_err;
      // New word on the capture cycle, otherwise continue the current one
      assign w_src   = w_capture ? w_fmt : r_shift;

      // Output format: test pattern > two's complement > offset binary
      always_comb begin
        w_fmt = {~w_adc[15], w_adc[14:0]};
        if (r_reg3[7])      w_fmt = w_pattern;
        else if (r_reg1[5]) w_fmt = w_adc;
      end

      // Each cycle emits W[15],W[14],W[7],W[6] and shifts the word left by 2
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          r_shift <= 16'd0;
          r_lanes <= 4'd0;
        end else begin
          r_shift <= {w_src[13:0], 2'b00};
          if (w_blank) r_lanes <= 4'd0;
          else         r_lanes <= {w_src[6], w_src[7], w_src[14], w_src[15]};
        end
      end
    end
  endgenerate

  assign D0_out = g_ch[0].r_lanes;
  assign D1_out = g_ch[1].r_lanes;

  // ---------------------------------------------------------------------
  // SPI input synchronizers and edge detection
  // ---------------------------------------------------------------------
  logic [SCK_SYNC_STAGES-1:0] r_scs_sync;
  logic [SCK_SYNC_STAGES-1:0] r_sck_sync;
  logic [SCK_SYNC_STAGES-1:0] r_sdi_sync;
  logic r_scs_d;
  logic r_sck_d;
  logic w_scs;
  logic w_sck;
  logic w_sdi;
  logic w_scs_fall;
  logic w_scs_rise;
  logic w_sck_rise;
  logic w_sck_fall;

  assign w_scs      = r_scs_sync[SCK_SYNC_STAGES-1];
  assign w_sck      = r_sck_sync[SCK_SYNC_STAGES-1];
  assign w_sdi      = r_sdi_sync[SCK_SYNC_STAGES-1];
  assign w_scs_fall = r_scs_d & ~w_scs;
  assign w_scs_rise = ~r_scs_d & w_scs;
  assign w_sck_rise = ~r_sck_d & w_sck;
  assign w_sck_fall = r_sck_d & ~w_sck;

  // Synchronizer chains; chip select idles high so it resets high
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_scs_sync <= '1;
      r_sck_sync <= '0;
      r_sdi_sync <= '0;
      r_scs_d    <= 1'b1;
      r_sck_d    <= 1'b0;
    end else begin
      r_scs_sync <= {r_scs_sync[SCK_SYNC_STAGES-2:0], spi_scs_in};
      r_sck_sync <= {r_sck_sync[SCK_SYNC_STAGES-2:0], spi_sck_in};
      r_sdi_sync <= {r_sdi_sync[SCK_SYNC_STAGES-2:0], spi_sdi_in};
      r_scs_d    <= w_scs;
      r_sck_d    <= w_sck;
    end
  end

  // ---------------------------------------------------------------------
  // SPI transfer FSM
  // ---------------------------------------------------------------------
  logic [1:0] r_state;
  logic [3:0] r_bit_cnt;
  logic [6:0] r_sr;
  logic       r_is_read;
  logic [6:0] r_addr;
  logic [7:0] r_sdo_sr;
  logic       r_sdo;
  logic [6:0] w_cmd_addr;
  logic [7:0] w_rd_data;
  logic [7:0] w_wdata;
  logic       w_commit;

  assign w_cmd_addr  = {r_sr[5:0], w_sdi};
  assign w_wdata     = {r_sr[6:0], w_sdi};
  assign w_commit    = (r_state == ST_DATA) && w_sck_rise && (r_bit_cnt == 4'd15) &&
                       !r_is_read && (r_addr <= 7'd4);
  assign spi_sdo_out = r_sdo;

  // Read-back mux; reg0 and unmapped addresses read as zero
  always_comb begin
    w_rd_data = 8'h00;
    case (w_cmd_addr)
      7'd1:    w_rd_data = r_reg1;
      7'd2:    w_rd_data = r_reg2;
      7'd3:    w_rd_data = r_reg3;
      7'd4:    w_rd_data = r_reg4;
      default: w_rd_data = 8'h00;
    endcase
  end

  // Command/data shifting, read-data launch on sck falling edges
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 4'd0;
      r_sr      <= 7'd0;
      r_is_read <= 1'b0;
      r_addr    <= 7'd0;
      r_sdo_sr  <= 8'd0;
      r_sdo     <= 1'b0;
    end else if (w_scs_rise) begin
      // Deselect ends any transfer; a short one never reached the commit
      r_state <= ST_IDLE;
      r_sdo   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sdo <= 1'b0;
          if (w_scs_fall) begin
            r_state   <= ST_CMD;
            r_bit_cnt <= 4'd0;
            r_is_read <= 1'b0;
          end
        end
        ST_CMD: begin
          if (w_sck_rise) begin
            r_sr      <= {r_sr[5:0], w_sdi};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              r_state   <= ST_DATA;
              r_is_read <= r_sr[6];
              r_addr    <= w_cmd_addr;
              r_sdo_sr  <= r_sr[6] ? w_rd_data : 8'h00;
            end
          end
        end
        ST_DATA: begin
          if (w_sck_rise) begin
            r_sr      <= {r_sr[5:0], w_sdi};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd15) r_state <= ST_DONE;
          end
          if (w_sck_fall && r_is_read) begin
            r_sdo    <= r_sdo_sr[7];
            r_sdo_sr <= {r_sdo_sr[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // Register file with write commit and one-cycle-delayed soft reset
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_reg1     <= 8'h00;
      r_reg2     <= 8'h01;
      r_reg3     <= 8'h00;
      r_reg4     <= 8'h00;
      r_soft_rst <= 1'b0;
    end else begin
      r_soft_rst <= w_commit && (r_addr == 7'd0) && w_wdata[7];
      if (r_soft_rst) begin
        r_reg1 <= 8'h00;
        r_reg2 <= 8'h01;
        r_reg3 <= 8'h00;
        r_reg4 <= 8'h00;
      end else if (w_commit) begin
        case (r_addr)
          7'd1:    r_reg1 <= w_wdata;
          7'd2:    r_reg2 <= w_wdata;
          7'd3:    r_reg3 <= w_wdata;
          7'd4:    r_reg4 <= w_wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ltc2195_emulator.sv
// Directed bench for ltc2195_emulator: frame capture, lane mapping,
// formatting modes, SPI read/write/abort, soft reset and async reset.
module tb_ltc2195_emulator;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] ADC0_in;
  logic [15:0] ADC1_in;
  logic        frame_strobe_out;
  logic [3:0]  D0_out;
  logic [3:0]  D1_out;
  logic        FR_out;
  logic        spi_scs_in;
  logic        spi_sck_in;
  logic        spi_sdi_in;
  logic        spi_sdo_out;
  logic        mode_err_out;

  int total = 0;
  int bad   = 0;

  logic [3:0] d0n [4];
  logic [3:0] d1n [4];
  logic [3:0] frn;
  logic [3:0] stbn;
  logic [3:0] errn;

  ltc2195_emulator #(.N_LANES(4), .SCK_SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .ADC0_in(ADC0_in), .ADC1_in(ADC1_in),
    .frame_strobe_out(frame_strobe_out),
    .D0_out(D0_out), .D1_out(D1_out), .FR_out(FR_out),
    .spi_scs_in(spi_scs_in), .spi_sck_in(spi_sck_in), .spi_sdi_in(spi_sdi_in),
    .spi_sdo_out(spi_sdo_out), .mode_err_out(mode_err_out)
  );

  always #5 clk_in = ~clk_in;

  // Receiver-side reconstruction: bit k (MSB first) of lane nibbles
  function automatic logic [15:0] recon(input logic [3:0] l0, input logic [3:0] l1,
                                        input logic [3:0] l2, input logic [3:0] l3);
    logic [15:0] w;
    w = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      w[15-2*k] = l0[3-k];
      w[14-2*k] = l1[3-k];
      w[7-2*k]  = l2[3-k];
      w[6-2*k]  = l3[3-k];
    end
    return w;
  endfunction

  // Wait for the capture cycle, then record the four bit-times that follow
  task automatic capture_frame();
    int guard;
    guard = 0;
    @(negedge clk_in);
    while (frame_strobe_out !== 1'b1 && guard < 16) begin
      @(negedge clk_in);
      guard++;
    end
    total++;
    if (frame_strobe_out !== 1'b1) begin
      bad++;
      $display("FAIL frame_wait: strobe=%b after %0d cycles, required 1", frame_strobe_out, guard);
    end
    for (int l = 0; l < 4; l++) begin
      d0n[l] = 4'h0;
      d1n[l] = 4'h0;
    end
    frn = 4'h0; stbn = 4'h0; errn = 4'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      for (int l = 0; l < 4; l++) begin
        d0n[l] = {d0n[l][2:0], D0_out[l]};
        d1n[l] = {d1n[l][2:0], D1_out[l]};
      end
      frn  = {frn[2:0], FR_out};
      stbn = {stbn[2:0], frame_strobe_out};
      errn = {errn[2:0], mode_err_out};
    end
  endtask

  // Full or truncated SPI transfer; rd collects sdo during bits 8..15
  task automatic spi_xfer(input logic [15:0] w, input int nbits, output logic [7:0] rd);
    rd = 8'h00;
    @(negedge clk_in);
    spi_scs_in = 1'b0;
    repeat (4) @(negedge clk_in);
    for (int i = 0; i < nbits; i++) begin
      spi_sck_in = 1'b0;
      spi_sdi_in = w[15-i];
      repeat (4) @(negedge clk_in);
      if (i >= 8) rd = {rd[6:0], spi_sdo_out};
      spi_sck_in = 1'b1;
      repeat (4) @(negedge clk_in);
    end
    spi_sck_in = 1'b0;
    repeat (4) @(negedge clk_in);
    spi_scs_in = 1'b1;
    spi_sdi_in = 1'b0;
    repeat (6) @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    spi_scs_in = 1'b1; spi_sck_in = 1'b0; spi_sdi_in = 1'b0;
    ADC0_in = 16'h8001; ADC1_in = 16'h7FFE;
    repeat (3) @(negedge clk_in);
    total++;
    if ({frame_strobe_out, D0_out, D1_out, FR_out, spi_sdo_out, mode_err_out} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 000",
               {frame_strobe_out, D0_out, D1_out, FR_out, spi_sdo_out, mode_err_out});
    end
    rst_in = 1'b0;
    $display("reset released");
  endtask

  task automatic test_offset_binary();
    capture_frame();
    $display("frame ch0 lanes %b %b %b %b fr %b", d0n[0], d0n[1], d0n[2], d0n[3], frn);
    total++;
    if (d0n[0] !== 4'b0000) begin bad++; $display("FAIL ob_ch0_lane0: got %b required 0000", d0n[0]); end
    total++;
    if (d0n[3] !== 4'b0001) begin bad++; $display("FAIL ob_ch0_lane3: got %b required 0001", d0n[3]); end
    total++;
    if (d1n[3] !== 4'b1110) begin bad++; $display("FAIL ob_ch1_lane3: got %b required 1110", d1n[3]); end
    total++;
    if (recon(d1n[0], d1n[1], d1n[2], d1n[3]) !== 16'hFFFE) begin
      bad++; $display("FAIL ob_ch1_word: got %h required fffe", recon(d1n[0], d1n[1], d1n[2], d1n[3]));
    end
    total++;
    if (frn !== 4'b1100) begin bad++; $display("FAIL fr_pattern: got %b required 1100", frn); end
    total++;
    if (stbn !== 4'b0001) begin bad++; $display("FAIL strobe_period: got %b required 0001", stbn); end
    total++;
    if (errn !== 4'b0000) begin bad++; $display("FAIL mode_err_default: got %b required 0000", errn); end
  endtask

  task automatic test_twos_complement();
    logic [7:0] rd;
    spi_xfer({1'b0, 7'h01, 8'h20}, 16, rd);
    $display("spi write reg1=20 sdo=%h", rd);
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL sdo_during_write: got %h required 00", rd); end
    ADC0_in = 16'h1234; ADC1_in = 16'hFEDC;
    capture_frame();
    $display("frame ch0 lanes %b %b %b %b", d0n[0], d0n[1], d0n[2], d0n[3]);
    total++;
    if ({d0n[0], d0n[1], d0n[2], d0n[3]} !== 16'b0001_0100_0100_0110) begin
      bad++; $display("FAIL tc_ch0_lanes: got %b required 0001010001000110", {d0n[0], d0n[1], d0n[2], d0n[3]});
    end
    total++;
    if (recon(d0n[0], d0n[1], d0n[2], d0n[3]) !== 16'h1234) begin
      bad++; $display("FAIL tc_ch0_word: got %h required 1234", recon(d0n[0], d0n[1], d0n[2], d0n[3]));
    end
    total++;
    if (recon(d1n[0], d1n[1], d1n[2], d1n[3]) !== 16'hFEDC) begin
      bad++; $display("FAIL tc_ch1_word: got %h required fedc", recon(d1n[0], d1n[1], d1n[2], d1n[3]));
    end
  endtask

  task automatic test_pattern();
    logic [7:0] rd;
    spi_xfer({1'b0, 7'h03, 8'h8A}, 16, rd);
    spi_xfer({1'b0, 7'h04, 8'h5C}, 16, rd);
    ADC0_in = 16'h1111; ADC1_in = 16'hAAAA;
    capture_frame();
    $display("pattern frame ch0=%h ch1=%h", recon(d0n[0], d0n[1], d0n[2], d0n[3]),
             recon(d1n[0], d1n[1], d1n[2], d1n[3]));
    total++;
    if (recon(d0n[0], d0n[1], d0n[2], d0n[3]) !== 16'h2970) begin
      bad++; $display("FAIL pattern_ch0: got %h required 2970", recon(d0n[0], d0n[1], d0n[2], d0n[3]));
    end
    total++;
    if (recon(d1n[0], d1n[1], d1n[2], d1n[3]) !== 16'h2970) begin
      bad++; $display("FAIL pattern_ch1: got %h required 2970", recon(d1n[0], d1n[1], d1n[2], d1n[3]));
    end
    ADC0_in = 16'h0F0F; ADC1_in = 16'h5555;
    capture_frame();
    total++;
    if (recon(d0n[0], d0n[1], d0n[2], d0n[3]) !== 16'h2970) begin
      bad++; $display("FAIL pattern_ch0_next: got %h required 2970", recon(d0n[0], d0n[1], d0n[2], d0n[3]));
    end
  endtask

  task automatic test_spi_read();
    logic [7:0] rd;
    spi_xfer({1'b1, 7'h01, 8'h00}, 16, rd);
    $display("spi read reg1 -> %h", rd);
    total++;
    if (rd !== 8'h20) begin bad++; $display("FAIL read_reg1: got %h required 20", rd); end
    spi_xfer({1'b1, 7'h04, 8'h00}, 16, rd);
    $display("spi read reg4 -> %h", rd);
    total++;
    if (rd !== 8'h5C) begin bad++; $display("FAIL read_reg4: got %h required 5c", rd); end
    spi_xfer({1'b1, 7'h10, 8'h00}, 16, rd);
    $display("spi read addr10 -> %h", rd);
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL read_unmapped: got %h required 00", rd); end
    // Leave test-pattern mode for the following tests
    spi_xfer({1'b0, 7'h03, 8'h00}, 16, rd);
  endtask

  task automatic test_lane_mode();
    logic [7:0] rd;
    ADC0_in = 16'h1234; ADC1_in = 16'hFEDC;
    spi_xfer({1'b0, 7'h02, 8'h00}, 16, rd);
    capture_frame();
    $display("bad mode frame d0=%b%b%b%b err=%b fr=%b", d0n[0], d0n[1], d0n[2], d0n[3], errn, frn);
    total++;
    if (errn !== 4'b1111) begin bad++; $display("FAIL mode_err_set: got %b required 1111", errn); end
    total++;
    if ({d0n[0], d0n[1], d0n[2], d0n[3], d1n[0], d1n[1], d1n[2], d1n[3]} !== 32'h0) begin
      bad++; $display("FAIL mode_lanes_zero: got %h required 0",
                      {d0n[0], d0n[1], d0n[2], d0n[3], d1n[0], d1n[1], d1n[2], d1n[3]});
    end
    total++;
    if (frn !== 4'b1100) begin bad++; $display("FAIL mode_fr_toggle: got %b required 1100", frn); end
    spi_xfer({1'b0, 7'h02, 8'h01}, 16, rd);
    capture_frame();
    $display("recovered frame ch0=%h err=%b", recon(d0n[0], d0n[1], d0n[2], d0n[3]), errn);
    total++;
    if (errn !== 4'b0000) begin bad++; $display("FAIL mode_err_clear: got %b required 0000", errn); end
    total++;
    if (recon(d0n[0], d0n[1], d0n[2], d0n[3]) !== 16'h1234) begin
      bad++; $display("FAIL mode_recover_word: got %h required 1234", recon(d0n[0], d0n[1], d0n[2], d0n[3]));
    end
  endtask

  task automatic test_abort_and_soft_reset();
    logic [7:0] rd;
    spi_xfer({1'b0, 7'h01, 8'hFF}, 10, rd);
    spi_xfer({1'b1, 7'h01, 8'h00}, 16, rd);
    $display("after aborted write reg1 -> %h", rd);
    total++;
    if (rd !== 8'h20) begin bad++; $display("FAIL abort_no_write: got %h required 20", rd); end
    spi_xfer({1'b0, 7'h04, 8'h77}, 16, rd);
    spi_xfer({1'b0, 7'h00, 8'h80}, 16, rd);
    spi_xfer({1'b1, 7'h01, 8'h00}, 16, rd);
    $display("after soft reset reg1 -> %h", rd);
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL softrst_reg1: got %h required 00", rd); end
    spi_xfer({1'b1, 7'h02, 8'h00}, 16, rd);
    total++;
    if (rd !== 8'h01) begin bad++; $display("FAIL softrst_reg2: got %h required 01", rd); end
    spi_xfer({1'b1, 7'h04, 8'h00}, 16, rd);
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL softrst_reg4: got %h required 00", rd); end
    spi_xfer({1'b1, 7'h00, 8'h00}, 16, rd);
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL read_reg0: got %h required 00", rd); end
    ADC0_in = 16'h1234;
    capture_frame();
    $display("offset binary after soft reset ch0=%h", recon(d0n[0], d0n[1], d0n[2], d0n[3]));
    total++;
    if (recon(d0n[0], d0n[1], d0n[2], d0n[3]) !== 16'h9234) begin
      bad++; $display("FAIL softrst_format: got %h required 9234", recon(d0n[0], d0n[1], d0n[2], d0n[3]));
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] rd;
    spi_xfer({1'b0, 7'h01, 8'h20}, 16, rd);
    ADC0_in = 16'hFFFF; ADC1_in = 16'hFFFF;
    // Begin a write to reg3 and interrupt it partway
    @(negedge clk_in);
    spi_scs_in = 1'b0;
    repeat (4) @(negedge clk_in);
    for (int i = 0; i < 5; i++) begin
      spi_sck_in = 1'b0; spi_sdi_in = 1'b1;
      repeat (4) @(negedge clk_in);
      spi_sck_in = 1'b1;
      repeat (4) @(negedge clk_in);
    end
    #2 rst_in = 1'b1;
    #1;
    $display("async reset asserted mid-transfer");
    total++;
    if ({frame_strobe_out, D0_out, D1_out, FR_out, spi_sdo_out, mode_err_out} !== 12'h000) begin
      bad++;
      $display("FAIL async_reset_outputs: got %h required 000",
               {frame_strobe_out, D0_out, D1_out, FR_out, spi_sdo_out, mode_err_out});
    end
    spi_scs_in = 1'b1; spi_sck_in = 1'b0; spi_sdi_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (4) @(negedge clk_in);
    spi_xfer({1'b1, 7'h01, 8'h00}, 16, rd);
    $display("after async reset reg1 -> %h", rd);
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL async_reset_reg1: got %h required 00", rd); end
    spi_xfer({1'b1, 7'h03, 8'h00}, 16, rd);
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL async_reset_reg3: got %h required 00", rd); end
    capture_frame();
    total++;
    if (recon(d0n[0], d0n[1], d0n[2], d0n[3]) !== 16'h7FFF) begin
      bad++; $display("FAIL async_reset_format: got %h required 7fff", recon(d0n[0], d0n[1], d0n[2], d0n[3]));
    end
  endtask

  initial begin
    test_reset();
    test_offset_binary();
    test_twos_complement();
    test_pattern();
    test_spi_read();
    test_lane_mode();
    test_abort_and_soft_reset();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
